// File: rtl/serial_loader_pkg.sv
// ============================================================================
//  Module   : serial_loader_pkg
//  Brief    : Shared state encoding and default width for serial_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_loader_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_loader.sv
// ============================================================================
//  Module   : serial_loader
//  Brief    : Framed serial-to-parallel front end producing d/load for a
//             downstream load register. Define SERIAL_LOADER_PARITY_EN to
//             add an even-parity bit after the data bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic             busy,
    output logic             par_err
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   w_d_nxt;
    logic               r_load;
    logic               w_load_nxt;
    logic [WIDTH-1:0]   w_word;
    logic               w_last_bit;

`ifdef SERIAL_LOADER_PARITY_EN
    logic               r_par_err;
    logic               w_par_err_nxt;
    logic               w_par_ok;

    // Even parity: data bits XOR parity bit must be zero.
    assign w_par_ok = ~(^r_shift ^ sin);
`endif

    // Current shift contents with the incoming bit dropped into slot r_cnt.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_word[i] = sin;
            end
        end
    end

    assign w_last_bit = (r_cnt == c_CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_d_nxt       = r_d;
        w_load_nxt    = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
        w_par_err_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (sin_valid && sin) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    w_shift_nxt = w_word;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (w_last_bit) begin
`ifdef SERIAL_LOADER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_d_nxt     = w_word;
                        w_load_nxt  = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_LOADER_PARITY_EN
            PARITY: begin
                if (sin_valid) begin
                    w_state_nxt = IDLE;
                    if (w_par_ok) begin
                        w_d_nxt    = r_shift;
                        w_load_nxt = 1'b1;
                    end else begin
                        w_par_err_nxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_d     <= '0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_d     <= w_d_nxt;
            r_load  <= w_load_nxt;
        end
    end

`ifdef SERIAL_LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_nxt;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign d    = r_d;
    assign load = r_load;
    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_loader.sv
// ============================================================================
//  Module   : tb_serial_loader
//  Brief    : Directed bench for serial_loader driving a 4-bit load register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_loader;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic [3:0] d;
    logic       load;
    logic       busy;
    logic       par_err;
    logic [3:0] r_q;

    int n_vec;
    int n_err;

    serial_loader #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .d         (d),
        .load      (load),
        .busy      (busy),
        .par_err   (par_err)
    );

    // Downstream 4-bit load register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= d;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; return at the next falling edge.
    task automatic drive(input logic v, input logic s);
        sin_valid = v;
        sin       = s;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[i]);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b1);
        rst = 1'b0;

        // 1: reset state, then frame 1,0,1,0
        chk("rst_d", d, 0);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", par_err, 0);
        drive(1'b1, 1'b1);
        chk("t1_busy_after_start", busy, 1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("t1_no_early_load", load, 0);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
        chk("t1_busy_parity", busy, 1);
        drive(1'b1, 1'b0);
`else
        drive(1'b1, 1'b0);
`endif
        chk("t1_load", load, 1);
        chk("t1_d", d, 5);
        chk("t1_busy_in_load", busy, 0);
        drive(1'b0, 1'b0);
        chk("t1_load_pulse_end", load, 0);
        chk("t1_q", r_q, 5);

        // 2: same frame with a two-cycle stall after the first data bit
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        chk("t2_gap1_busy", busy, 1);
        chk("t2_gap1_load", load, 0);
        drive(1'b0, 1'b1);
        chk("t2_gap2_busy", busy, 1);
        chk("t2_gap2_load", load, 0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("t2_no_early_load", load, 0);
        drive(1'b1, 1'b0);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
`endif
        chk("t2_load", load, 1);
        chk("t2_d", d, 5);
        drive(1'b0, 1'b0);

        // 3: idle zeros are not start bits, then frame 9
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            chk("t3_idle_busy", busy, 0);
            chk("t3_idle_load", load, 0);
        end
        drive(1'b1, 1'b1);
        send_bits(4'd9);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
`endif
        chk("t3_load", load, 1);
        chk("t3_d", d, 9);
        drive(1'b0, 1'b0);

        // 4: reset mid-frame discards it, then frame 12
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b1);
        rst = 1'b0;
        chk("t4_rst_d", d, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_load", load, 0);
        chk("t4_rst_q", r_q, 0);
        drive(1'b1, 1'b1);
        send_bits(4'd12);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
`endif
        chk("t4_load", load, 1);
        chk("t4_d", d, 12);
        drive(1'b0, 1'b0);
        chk("t4_q", r_q, 12);

        // 5: back-to-back frames, start bit in the load cycle
        drive(1'b1, 1'b1);
        send_bits(4'd5);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
`endif
        chk("t5_load_a", load, 1);
        chk("t5_d_a", d, 5);
        drive(1'b1, 1'b1);
        chk("t5_start_accepted", busy, 1);
        chk("t5_load_a_end", load, 0);
        chk("t5_q_a", r_q, 5);
        send_bits(4'd9);
`ifdef SERIAL_LOADER_PARITY_EN
        drive(1'b1, 1'b0);
`endif
        chk("t5_load_b", load, 1);
        chk("t5_d_b", d, 9);
        drive(1'b0, 1'b0);
        chk("t5_q_b", r_q, 9);
        chk("t5_perr_quiet", par_err, 0);

`ifdef SERIAL_LOADER_PARITY_EN
        // 6: good parity loads, bad parity strobes par_err and keeps d
        drive(1'b1, 1'b1);
        send_bits(4'd5);
        chk("t6_wait_parity", load, 0);
        drive(1'b1, 1'b0);
        chk("t6_load_ok", load, 1);
        chk("t6_d_ok", d, 5);
        chk("t6_perr_ok", par_err, 0);
        drive(1'b1, 1'b1);
        send_bits(4'd12);
        drive(1'b1, 1'b1);
        chk("t6_perr", par_err, 1);
        chk("t6_no_load", load, 0);
        chk("t6_d_kept", d, 5);
        chk("t6_busy", busy, 0);
        drive(1'b0, 1'b0);
        chk("t6_perr_end", par_err, 0);
        chk("t6_q_kept", r_q, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
